// File: rtl/booth_r4_mult.sv
// booth_r4_mult -- radix-4 (modified Booth) sequential multiplier.
//
// Retires two multiplier bits per cycle. Signed or unsigned operands are
// selected per operation. This unit is a shared multi-cycle multiply resource
// driven by a start/busy/done handshake.
//
// Parameters:
//   DATAWIDTH    operand width W (>= 4); the product is 2W bits
//
// Ports:
//   clk          clock; all logic acts on the rising edge
//   rst          synchronous reset, active-high; aborts any operation in flight
//   start        request; sampled only while busy is low (IDLE or DONE_S)
//   signed_mode  1: A and B are two's complement; 0: unsigned; latched on accept
//   A            multiplicand, latched on accept
//   B            multiplier, latched on accept
//   busy         high while the multiply iterates
//   done         one-cycle pulse; product is valid in this cycle
//   product      result; held until the next done
//
// Optional feature macro: BOOTH_EARLY_TERM_EN
//   When defined, iteration stops as soon as every remaining Booth digit is
//   zero, and the accumulator is realigned with one variable arithmetic shift.
//   When undefined, exactly N iteration cycles run and no variable shifter is
//   built. Results are identical in both builds.
module booth_r4_mult #(
  parameter int DATAWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     signed_mode,
  input  logic [DATAWIDTH-1:0]     A,
  input  logic [DATAWIDTH-1:0]     B,
  output logic                     busy,
  output logic                     done,
  output logic [2*DATAWIDTH-1:0]   product
);

  localparam int W  = DATAWIDTH;
  localparam int XW = 2 * ((W + 2) / 2);  // extended operand width (even, >= W+1)
  localparam int N  = XW / 2;             // number of Booth digits
  localparam int PW = XW + 2;             // accumulator width, with sign guard
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE_S} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt_p0;
  logic signed [XW-1:0]    a_p0;
  logic signed [XW-1:0]    mq_p0;
  logic                    guard_p0;
  logic signed [PW-1:0]    acc_p0;
  logic [XW-1:0]           lo_p0;

  logic                    accept;
  logic                    early;
  logic signed [XW-1:0]    mq_nx;
  logic signed [PW-1:0]    sum;
  logic signed [PW+XW-1:0] wide;
  logic signed [PW+XW-1:0] wide_sh;

  // Sign- or zero-extend an operand to the Booth width.
  function automatic logic [XW-1:0] extend(input logic [W-1:0] v, input logic sgn);
    return sgn ? {{(XW-W){v[W-1]}}, v} : {{(XW-W){1'b0}}, v};
  endfunction

  // Partial product for one recoded digit; negatives are inverted operand plus 1.
  function automatic logic [PW-1:0] booth_pp(input logic [XW-1:0] a, input logic [2:0] d);
    logic [PW-1:0] ax;
    logic [PW-1:0] ax2;
    ax  = {{2{a[XW-1]}}, a};
    ax2 = ax << 1;
    case (d)
      3'b001, 3'b010: return ax;
      3'b011:         return ax2;
      3'b100:         return ~ax2 + PW'(1);
      3'b101, 3'b110: return ~ax + PW'(1);
      default:        return '0;
    endcase
  endfunction

  assign busy  = (state == CALC);
  assign done  = (state == DONE_S);

  assign mq_nx = mq_p0 >>> 2;
  assign sum   = acc_p0 + booth_pp(a_p0, {mq_p0[1:0], guard_p0});
  assign wide  = {sum, lo_p0};

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining multiplier bits plus the next guard all equal -> every later digit is 0.
  logic [$clog2(PW+XW+1)-1:0] sh_amt;
  assign early   = (&{mq_nx, mq_p0[1]}) | ~(|{mq_nx, mq_p0[1]});
  assign sh_amt  = ($clog2(PW+XW+1))'(2 * (N - int'(cnt_p0)));
  assign wide_sh = wide >>> sh_amt;
`else
  assign early   = 1'b0;
  assign wide_sh = wide >>> 2;
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE, DONE_S: begin
        if (start) begin
          accept  = 1'b1;
          state_n = CALC;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (cnt_p0 == CW'(N - 1) || early) state_n = DONE_S;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control: state, digit counter and the visible product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt_p0  <= '0;
      product <= '0;
    end else begin
      state <= state_n;
      if (accept) cnt_p0 <= '0;
      else if (state == CALC) cnt_p0 <= cnt_p0 + CW'(1);
      if (state == CALC && state_n == DONE_S) product <= wide_sh[2*W-1:0];
    end
  end

  // Datapath: operand latch, then one add-and-shift per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0     <= extend(A, signed_mode);
      mq_p0    <= extend(B, signed_mode);
      guard_p0 <= 1'b0;
      acc_p0   <= '0;
      lo_p0    <= '0;
    end else if (state == CALC) begin
      acc_p0   <= wide_sh[PW+XW-1:XW];
      lo_p0    <= wide_sh[XW-1:0];
      mq_p0    <= mq_nx;
      guard_p0 <= mq_p0[1];
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
module tb_booth_r4_mult;

  localparam int W  = 8;
  localparam int XW = 10;
  localparam int N  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  logic           start7 = 1'b0;
  logic           sm7 = 1'b0;
  logic [6:0]     A7 = '0;
  logic [6:0]     B7 = '0;
  logic           busy7, done7;
  logic [13:0]    product7;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_r4_mult #(.DATAWIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done), .product(product)
  );

  booth_r4_mult #(.DATAWIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .start(start7), .signed_mode(sm7),
    .A(A7), .B(B7), .busy(busy7), .done(done7), .product(product7)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected done cycle (relative to the accept edge) for the W=8 instance.
  function automatic int exp_lat(input logic [7:0] b, input logic sm);
`ifdef BOOTH_EARLY_TERM_EN
    logic [XW-1:0] bx;
    bx = sm ? {{2{b[7]}}, b} : {2'b00, b};
    for (int c = 0; c < N - 1; c++) begin
      logic same;
      same = 1'b1;
      for (int j = 2 * c + 1; j < XW; j++) if (bx[j] != bx[XW-1]) same = 1'b0;
      if (same) return c + 2;
    end
    return N + 1;
`else
    return N + 1;
`endif
  endfunction

  // Called at a negedge; returns just after the accept edge with inputs scrambled.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sm);
    start = 1'b1; A = a; B = b; signed_mode = sm;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    signed_mode = ~sm;
  endtask

  // Counts cycles after the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat, output logic [15:0] p);
    lat = -1;
    p   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        p   = product;
        break;
      end
    end
  endtask

  vec_t vecs[12];

  initial begin
    int          lat;
    int          lat7;
    logic [15:0] p;
    logic [13:0] p7;
    logic        seen;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[3]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[4]  = '{8'h05, 8'h01, 1'b1, 16'h0005};
    vecs[5]  = '{8'h00, 8'h00, 1'b0, 16'h0000};
    vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[7]  = '{8'hFF, 8'h80, 1'b0, 16'h7F80};
    vecs[8]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[10] = '{8'h01, 8'h80, 1'b1, 16'hFF80};
    vecs[11] = '{8'h03, 8'h05, 1'b0, 16'h000F};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of vectors: product and done latency
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sm);
      wait_done(lat, p);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].b, vecs[i].sm)));
      @(negedge clk);
    end

    // Unsigned 0xFF*0xFF: busy profile, single-cycle done, product hold
    launch(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    check("t1_busy_first_cycle", 32'(busy), 32'd1);
    wait_done(lat, p);
    check("t1_latency", 32'(lat + 1), 32'(exp_lat(8'hFF, 1'b0)));
    check("t1_product", 32'(p), 32'hFE01);
    check("t1_busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_product_hold", 32'(product), 32'hFE01);

    // Back-to-back: start held in the DONE_S cycle
    launch(8'hFF, 8'hFF, 1'b0);
    wait_done(lat, p);
    check("b2b_first_product", 32'(p), 32'hFE01);
    launch(8'h03, 8'h05, 1'b0);
    @(negedge clk);
    check("b2b_no_idle_gap", 32'(busy), 32'd1);
    wait_done(lat, p);
    check("b2b_latency", 32'(lat + 1), 32'(exp_lat(8'h05, 1'b0)));
    check("b2b_product", 32'(p), 32'h000F);
    @(negedge clk);

    // start pulsed mid-CALC is ignored
    launch(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; A = 8'h77; B = 8'h99; signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, p);
    check("ignore_latency", 32'(lat + 3), 32'(exp_lat(8'h34, 1'b0)));
    check("ignore_product", 32'(p), 32'h03A8);
    @(negedge clk);
    check("ignore_no_restart_busy", 32'(busy), 32'd0);
    check("ignore_no_restart_done", 32'(done), 32'd0);

    // Reset in the 3rd CALC cycle aborts with no done pulse
    launch(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // W=7 instance: unsigned 127*127
    start7 = 1'b1; A7 = 7'h7F; B7 = 7'h7F; sm7 = 1'b0;
    @(posedge clk);
    #1;
    start7 = 1'b0; A7 = '0; B7 = '0;
    lat7 = -1;
    p7 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done7) begin
        lat7 = i;
        p7 = product7;
        break;
      end
    end
    check("w7_latency", 32'(lat7), 32'd5);
    check("w7_product", 32'(p7), 32'h3F01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
